dm_responder: RTL and testbench

- Multi-cycle data-memory responder. It sits on the far side of the M-stage load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake and models a configurable access latency.
- Returns load data, byte/half-extended per the DMOp code, over a valid/ready response channel.
- The pipeline holds M-stage (stalls) while req_ready or rsp_valid is low.

---
 rtl/dm_responder_pkg.sv | 30 +++
 rtl/dm_responder_if.sv | 25 ++
 rtl/dm_responder_lane_unit.sv | 68 ++++++
 rtl/dm_responder.sv | 146 ++++++++++++++
 tb/tb_dm_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_responder_pkg.sv
// Shared constants for the data-memory responder: DMOp codes, FSM states,
// default geometry and an alignment helper.
package dm_responder_pkg;

    localparam int DM_DEPTH_DEF   = 3072;
    localparam int DM_ADDR_W_DEF  = 12;
    localparam int DM_LATENCY_DEF = 2;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Unknown ops are never flagged as misaligned; they are silently ignored.
    function automatic logic dm_misaligned(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            DM_W:        return (lane != 2'b00);
            DM_H, DM_HU: return lane[0];
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response handshake bundle between the M stage (master) and the
// data-memory responder (slave).
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_responder_lane_unit.sv
// Combinational lane logic: store byte-merge and load extract/extend for a
// little-endian 32-bit word. Shared with the M-stage data memory.
module dm_lane_unit
    import dm_responder_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged,
    output logic        o_known,
    output logic        o_misaligned
);
    logic [3:0]  w_be;
    logic [31:0] w_wrep;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick it.
    always_comb begin
        w_be    = 4'b0000;
        w_wrep  = i_wdata;
        o_load  = '0;
        o_known = 1'b1;
        case (i_op)
            DM_W: begin
                w_be   = 4'b1111;
                w_wrep = i_wdata;
                o_load = i_word;
            end
            DM_H, DM_HU: begin
                w_be   = i_lane[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{i_wdata[15:0]}};
                o_load = (i_op == DM_H) ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
            end
            DM_B, DM_BU: begin
                w_be   = 4'b0001 << i_lane;
                w_wrep = {4{i_wdata[7:0]}};
                o_load = (i_op == DM_B) ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
            end
            default: begin
                o_known = 1'b0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign o_merged[8*gi +: 8] = w_be[gi] ? w_wrep[8*gi +: 8] : i_word[8*gi +: 8];
        end
    endgenerate

    assign o_misaligned = dm_misaligned(i_op, i_lane);

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with configurable access latency.
// Optional macro DM_WRITE_LOG_EN: log every committed store with $display.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH   = DM_DEPTH_DEF,
    parameter int ADDR_W  = DM_ADDR_W_DEF,
    parameter int LATENCY = DM_LATENCY_DEF
)(
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus
);
    localparam int              CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dm_state_e        r_state;
    dm_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      r_rdata;
    logic [31:0]      w_rdata_next;
    logic             r_err;
    logic             w_err_next;

    logic             r_we;
    logic [2:0]       r_op;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_pc;

    logic [31:0]      r_mem [DEPTH];

    logic             w_accept;
    logic             w_commit;
    logic             w_req_ready;
    logic             w_rsp_valid;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_load;
    logic [31:0]      w_merged;
    logic             w_known;
    logic             w_misaligned;

    assign w_idx     = r_addr[ADDR_W+1:2];
    assign w_rd_word = r_mem[w_idx];

    dm_lane_unit u_lane (
        .i_op         (r_op),
        .i_lane       (r_addr[1:0]),
        .i_word       (w_rd_word),
        .i_wdata      (r_wdata),
        .o_load       (w_load),
        .o_merged     (w_merged),
        .o_known      (w_known),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rdata_next = r_rdata;
        w_err_next   = r_err;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    // Stores, errors and unknown ops all return zero data.
                    w_err_next   = w_known && w_misaligned;
                    w_rdata_next = (r_we || !w_known || w_misaligned) ? 32'h0 : w_load;
                    w_commit     = r_we && w_known && !w_misaligned;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_accept) begin
            r_we    <= bus.req_we;
            r_op    <= bus.req_op;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_pc    <= bus.req_pc;
        end
    end

    // Reset wipes the whole array, so an interrupted store can never land.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
`ifdef DM_WRITE_LOG_EN
            $display("%d@%h: *%h <= %h", $time, r_pc, {r_addr[31:2], 2'b00}, w_merged);
`endif
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    logic w_unused;
    assign w_unused = &{1'b0, r_addr[31:ADDR_W+2], r_pc};

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: byte-array reference model, per-cycle
// handshake/data compare, and literal expectations from hand-worked vectors.
module tb_dm_responder;
    import dm_responder_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if bus();

    dm_responder #(.DEPTH(3072), .ADDR_W(12), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mb [0:16383];
    bit          pending = 1'b0;
    int          acc_cyc = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            DM_W:        return 4;
            DM_H, DM_HU: return 2;
            DM_B, DM_BU: return 1;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_misaligned(input logic [2:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        return (sz != 0) && ((int'(addr[1:0]) % sz) != 0);
    endfunction

    // Reference: read sz bytes little-endian from the byte array, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        int a  = int'(addr[13:0]);
        logic [31:0] v = '0;
        if (sz == 0 || is_misaligned(op, addr)) return 32'h0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = mb[a + k];
        if ((op == DM_H || op == DM_B) && v[8*sz-1])
            for (int j = 8*sz; j < 32; j++) v[j] = 1'b1;
        return v;
    endfunction

    task automatic model_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int sz = op_size(op);
        int a  = int'(addr[13:0]);
        if (sz == 0 || is_misaligned(op, addr)) return;
        for (int k = 0; k < sz; k++) mb[a + k] = wdata[8*k +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
    endtask

    // Per-cycle compare of handshake and response data against the model.
    always @(negedge clk) begin
        bit exp_v;
        if (reset) begin
            exp_v = pending && ((cyc - acc_cyc) >= LAT);
            chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !pending});
            chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_v});
            if (exp_v) begin
                chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
                chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
            end
        end
    end

    task automatic txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = 32'h0000_1000 + addr;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        // Scramble the ignored request fields while the access is in flight.
        bus.req_we    = ~we;
        bus.req_op    = op ^ 3'd1;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        pending   = 1'b1;
        acc_cyc   = cyc;
        exp_err   = is_misaligned(op, addr);
        exp_rdata = we ? 32'h0 : model_load(op, addr);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 20);
        chk("rsp_arrives", {31'b0, bus.rsp_valid}, 32'd1);
        last_lat   = cyc - acc_cyc;
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        if (hold > 0) begin
            chk("hold_stable", bus.rsp_rdata, last_rdata);
            chk("hold_ready_low", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        if (we) model_store(op, addr, wdata);
        pending = 1'b0;
        $display("txn we=%0d op=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, op, addr, wdata, last_rdata, last_err, last_lat);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_op    = DM_W;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_pc    = '0;
        bus.rsp_ready = 1'b0;
        model_clear();

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);

        txn(1'b0, DM_W, 32'h0, 32'h0, 0);
        chk("load0_after_reset", last_rdata, 32'h0);

        txn(1'b1, DM_W, 32'h10, 32'h12345678, 0);
        chk("store_latency", last_lat, 32'd2);
        chk("store_rdata", last_rdata, 32'h0);
        txn(1'b0, DM_W, 32'h10, 32'h0, 0);
        chk("load_w", last_rdata, 32'h12345678);
        chk("load_latency", last_lat, 32'd2);

        txn(1'b1, DM_B, 32'h13, 32'h000055AA, 0);
        txn(1'b1, DM_H, 32'h10, 32'h1234BEEF, 0);
        txn(1'b0, DM_W, 32'h10, 32'h0, 0);
        chk("merge_w", last_rdata, 32'hAA34BEEF);

        txn(1'b0, DM_B,  32'h13, 32'h0, 0);  chk("ld_b_13",  last_rdata, 32'hFFFFFFAA);
        txn(1'b0, DM_BU, 32'h13, 32'h0, 0);  chk("ld_bu_13", last_rdata, 32'h000000AA);
        txn(1'b0, DM_H,  32'h10, 32'h0, 0);  chk("ld_h_10",  last_rdata, 32'hFFFFBEEF);
        txn(1'b0, DM_HU, 32'h10, 32'h0, 0);  chk("ld_hu_10", last_rdata, 32'h0000BEEF);
        txn(1'b0, DM_B,  32'h11, 32'h0, 0);  chk("ld_b_11",  last_rdata, 32'hFFFFFFBE);
        txn(1'b0, DM_BU, 32'h12, 32'h0, 0);  chk("ld_bu_12", last_rdata, 32'h00000034);
        txn(1'b0, DM_H,  32'h12, 32'h0, 0);  chk("ld_h_12",  last_rdata, 32'hFFFFAA34);

        txn(1'b1, DM_W, 32'h12, 32'hCAFEF00D, 0);
        chk("mis_st_err", {31'b0, last_err}, 32'd1);
        chk("mis_st_rdata", last_rdata, 32'h0);
        txn(1'b0, DM_W, 32'h10, 32'h0, 0);
        chk("mis_st_unchanged", last_rdata, 32'hAA34BEEF);
        txn(1'b0, DM_H, 32'h11, 32'h0, 0);
        chk("mis_ld_err", {31'b0, last_err}, 32'd1);
        chk("mis_ld_rdata", last_rdata, 32'h0);

        txn(1'b0, DM_W, 32'h10, 32'h0, 4);
        chk("bp_rdata", last_rdata, 32'hAA34BEEF);

        txn(1'b1, 3'd7, 32'h10, 32'hFFFFFFFF, 0);
        chk("unk_st_err", {31'b0, last_err}, 32'd0);
        txn(1'b0, 3'd7, 32'h10, 32'h0, 0);
        chk("unk_ld_rdata", last_rdata, 32'h0);
        txn(1'b0, DM_W, 32'h10, 32'h0, 0);
        chk("unk_st_nowrite", last_rdata, 32'hAA34BEEF);

        txn(1'b1, DM_BU, 32'h15, 32'h00000080, 0);
        txn(1'b0, DM_B, 32'h15, 32'h0, 0);
        chk("ld_b_15", last_rdata, 32'hFFFFFF80);
        txn(1'b0, DM_W, 32'h14, 32'h0, 0);
        chk("ld_w_14", last_rdata, 32'h00008000);

        // Reset while the store sits in WAIT: it must never commit.
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_op    = DM_W;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        pending   = 1'b1;
        acc_cyc   = cyc;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b1;
        pending = 1'b0;
        model_clear();
        @(negedge clk);
        chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        txn(1'b0, DM_W, 32'h20, 32'h0, 0);
        chk("midrst_load_20", last_rdata, 32'h0);
        txn(1'b0, DM_W, 32'h10, 32'h0, 0);
        chk("midrst_load_10", last_rdata, 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
